// File: rtl/write_memory_controller.sv
// -----------------------------------------------------------------------------
// write_memory_controller
//
// Write-side companion of the input-memory read controller. Pixel-word write
// requests (address + one 3x3x12-bit window) arrive over valid/ready, are
// buffered in a small FIFO and drained in arrival order into the input memory
// port as a registered write strobe. Each write is held stable until the
// memory accepts it (mem_ready on an edge with mem_we=1).
//
// Optional feature: define WMC_BOUNDS_CHECK_EN to drop requests whose address
// is >= MEM_DEPTH. A dropped request still completes its handshake and raises
// err for one cycle. Without the macro every address is forwarded, err is tied
// to 0 and MEM_DEPTH only takes part in the parameter sanity check.
//
// Ports
//   clk, rst    clock, synchronous active-high reset
//   in_valid    upstream request valid
//   in_ready    upstream may push: FIFO not full and not in reset (combinational)
//   in_addr     request address
//   in_data     request data word
//   mem_we      registered memory write enable
//   mem_addr    registered memory address (holds last value while mem_we=0)
//   mem_wdata   registered memory write data (holds last value while mem_we=0)
//   mem_ready   memory accepts the write on an edge where mem_we=1
//   wr_done     one-cycle pulse per completed memory write
//   wr_count    completed-write counter, wraps 0xFFFF -> 0
//   busy        FIFO non-empty or a write in flight
//   err         one-cycle pulse per dropped out-of-range request
// -----------------------------------------------------------------------------
module write_memory_controller #(
    parameter int ADD_SIZE   = 12,
    parameter int DATA_SIZE  = 108,
    parameter int FIFO_DEPTH = 4,
    parameter int MEM_DEPTH  = 3072
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [ADD_SIZE-1:0]  in_addr,
    input  logic [DATA_SIZE-1:0] in_data,
    output logic                 mem_we,
    output logic [ADD_SIZE-1:0]  mem_addr,
    output logic [DATA_SIZE-1:0] mem_wdata,
    input  logic                 mem_ready,
    output logic                 wr_done,
    output logic [15:0]          wr_count,
    output logic                 busy,
    output logic                 err
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);
    localparam logic [CNT_W-1:0] ONE_CNT  = CNT_W'(1);
    localparam logic [PTR_W-1:0] ONE_PTR  = PTR_W'(1);

    // The pointer arithmetic relies on natural wrap, so depth must be a power of two.
    if ((FIFO_DEPTH < 2) || ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) || (MEM_DEPTH < 1)) begin : g_param_check
        $error("write_memory_controller: FIFO_DEPTH must be a power of two >= 2 and MEM_DEPTH >= 1");
    end

    typedef enum logic {
        IDLE  = 1'b0,
        ISSUE = 1'b1
    } state_t;

    state_t               state;
    logic [ADD_SIZE-1:0]  fifo_addr [FIFO_DEPTH];
    logic [DATA_SIZE-1:0] fifo_data [FIFO_DEPTH];
    logic [PTR_W-1:0]     wptr;
    logic [PTR_W-1:0]     rptr;
    logic [PTR_W-1:0]     rptr_nxt;
    logic [CNT_W-1:0]     count;
    logic                 drop;
    logic                 push;
    logic                 pop;

    // Full refuses a push even when a pop happens on the same edge.
    assign in_ready = (count != FULL_CNT) && !rst;

`ifdef WMC_BOUNDS_CHECK_EN
    localparam logic [ADD_SIZE:0] MEM_LIMIT = (ADD_SIZE + 1)'(MEM_DEPTH);

    assign drop = in_valid && in_ready && ({1'b0, in_addr} >= MEM_LIMIT);

    always_ff @(posedge clk) begin
        if (rst) begin
            err <= 1'b0;
        end else begin
            err <= drop;
        end
    end
`else
    assign drop = 1'b0;
    assign err  = 1'b0;
`endif

    assign push     = in_valid && in_ready && !drop;
    // mem_we is high exactly while in ISSUE, so this is the memory handshake.
    assign pop      = (state == ISSUE) && mem_ready;
    assign rptr_nxt = rptr + ONE_PTR;
    // The head entry stays counted while it is being issued.
    assign busy     = (count != '0) || mem_we;

    // Request storage: data only, no reset needed.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_addr[wptr] <= in_addr;
            fifo_data[wptr] <= in_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            wptr      <= '0;
            rptr      <= '0;
            count     <= '0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            wr_done   <= 1'b0;
            wr_count  <= '0;
        end else begin
            wr_done <= pop;

            if (push) begin
                wptr <= wptr + ONE_PTR;
            end

            if (pop) begin
                rptr     <= rptr_nxt;
                wr_count <= wr_count + 16'd1;
            end

            unique case ({push, pop})
                2'b10:   count <= count + ONE_CNT;
                2'b01:   count <= count - ONE_CNT;
                default: count <= count;
            endcase

            unique case (state)
                IDLE: begin
                    if (count != '0) begin
                        state     <= ISSUE;
                        mem_we    <= 1'b1;
                        mem_addr  <= fifo_addr[rptr];
                        mem_wdata <= fifo_data[rptr];
                    end
                end
                ISSUE: begin
                    if (mem_ready) begin
                        // Only entries already present before this edge chain
                        // back-to-back; a same-edge push into an emptying FIFO
                        // is picked up by the IDLE path on the next edge.
                        if (count > ONE_CNT) begin
                            mem_addr  <= fifo_addr[rptr_nxt];
                            mem_wdata <= fifo_data[rptr_nxt];
                        end else begin
                            mem_we <= 1'b0;
                            state  <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
